gp_register_bank: RTL and testbench
===================================

GP_REGISTER_BANK -- requirements
Module: gp_register_bank

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL provide parameter NUM_REGS, default 8, number of registers; legal values are 1 to 15.
REQ-003 SHALL provide parameter SEL_W, default 4, selector width; SEL_W SHALL satisfy 2^SEL_W > NUM_REGS.
REQ-004 SHALL provide parameter RESET_VAL, default 32'h0000_0888, reset value of every register, truncated or zero-extended to DATA_W.
REQ-005 SHALL provide parameter STEP, default 4, increment/decrement amount, taken modulo 2^DATA_W.
REQ-006 SHALL have port clock_6  input  1  clock; all state updates occur on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port read_or_write  input  SEL_W  write select; code k (1..NUM_REGS) targets register k-1; 0 or >NUM_REGS means no write.
REQ-009 SHALL have port write_mode  input  2  write operation: 00 load, 01 increment, 10 decrement, 11 byte-merge.
REQ-010 SHALL have port byte_en  input  DATA_W/8  per-byte lane enable, used only in byte-merge mode.
REQ-011 SHALL have port write_data  input  DATA_W  load/merge data.
REQ-012 SHALL have port rd_sel_a  input  SEL_W  read port A select, same coding as read_or_write.
REQ-013 SHALL have port rd_sel_b  input  SEL_W  read port B select, same coding as read_or_write.
REQ-014 SHALL have port clear_wrap  input  1  synchronous clear of wrap_flag.
REQ-015 SHALL have port rd_data_a  output  DATA_W  port A read data.
REQ-016 SHALL have port rd_data_b  output  DATA_W  port B read data.
REQ-017 SHALL have port wrap_flag  output  1  sticky inc/dec wrap-around indicator.

Function
REQ-018 Load (00) SHALL set reg[k-1] to write_data at the clock_6 edge.
REQ-019 Increment (01) SHALL set reg[k-1] to (reg[k-1] + STEP) mod 2^DATA_W; write_data SHALL be ignored.
REQ-020 Decrement (10) SHALL set reg[k-1] to (reg[k-1] - STEP) mod 2^DATA_W; write_data SHALL be ignored.
REQ-021 Byte-merge (11) SHALL replace each byte lane i where byte_en[i]=1 with write_data lane i and SHALL retain the other lanes; byte_en all-zero SHALL leave the register unchanged.
REQ-022 At most one register SHALL change per edge; non-selected registers SHALL hold their values.
REQ-023 An invalid select (0 or >NUM_REGS) SHALL change no register and SHALL not affect wrap_flag.
REQ-024 Read ports SHALL be combinational from stored state, with zero added latency and no write bypass: a same-cycle read of the register being written SHALL return the old value until the edge.
REQ-025 A read select of 0 or >NUM_REGS SHALL return all zeros.
REQ-026 Both read ports SHALL be able to select the same register simultaneously and SHALL return identical data.
REQ-027 An increment that carries out of bit DATA_W-1, or a decrement that borrows, SHALL set wrap_flag at the same edge as the register update.
REQ-028 wrap_flag SHALL remain set until reset or an edge with clear_wrap=1.
REQ-029 If clear_wrap=1 at the same edge as a new wrap event, the set SHALL win and wrap_flag SHALL be 1.
REQ-030 Load and byte-merge SHALL never set wrap_flag.

Reset
REQ-031 Assertion of reset SHALL immediately, without a clock edge, force every register to RESET_VAL and wrap_flag to 0.
REQ-032 While reset is high, all writes and clear_wrap SHALL be ignored; rd_data_a/b SHALL reflect RESET_VAL for valid selects and zero otherwise.
REQ-033 Reset asserted mid-sequence (between edges or coincident with an edge) SHALL discard the pending operation.
REQ-034 The first edge after reset deassertion SHALL perform a normal write.

Verification
REQ-035 Reset, then read all selects 0..15 (defaults) -> regs 1..8 read 32'h0000_0888; selects 0 and 9..15 read 0; wrap_flag=0.
REQ-036 Load sel=6, data 32'hDEAD_BEEF; read port A sel=6 in the same cycle -> 0x888; after the edge both ports sel=6 -> 32'hDEAD_BEEF; the other regs are unchanged.
REQ-037 Load sel=2 with 32'hFFFF_FFFE, then increment -> 32'h0000_0002 and wrap_flag=1; next edge with clear_wrap=1 -> wrap_flag=0.
REQ-038 Load sel=3 with 32'h0000_0002, then decrement while clear_wrap=1 -> 32'hFFFF_FFFE and wrap_flag=1 (set wins).
REQ-039 Byte-merge sel=1 (reg = 0x888), byte_en=4'b1010, data 32'h1122_3344 -> 32'h1100_3388.
REQ-040 Write sel=4 with reset pulsed asynchronously mid-cycle -> reg3 returns to 0x888 immediately; the write is not applied; the next edge performs a normal write.

Source files
------------

// File: rtl/gp_register_bank.sv
// General-purpose register bank: one write port (load/inc/dec/byte-merge), two
// combinational read ports, and a sticky wrap-around flag for inc/dec overflow.
module gp_register_bank #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned SEL_W     = 4,
    parameter logic [63:0] RESET_VAL = 64'h0000_0000_0000_0888,
    parameter int unsigned STEP      = 4
) (
    input  logic                  clock_6,
    input  logic                  reset,
    input  logic [SEL_W-1:0]      read_or_write,
    input  logic [1:0]            write_mode,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [SEL_W-1:0]      rd_sel_a,
    input  logic [SEL_W-1:0]      rd_sel_b,
    input  logic                  clear_wrap,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  wrap_flag
);

    localparam int unsigned       NUM_BYTES = DATA_W / 8;
    localparam logic [DATA_W-1:0] RST_V     = DATA_W'(RESET_VAL);
    localparam logic [DATA_W-1:0] STEP_V    = DATA_W'(STEP);

    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_INC   = 2'b01;
    localparam logic [1:0] MODE_DEC   = 2'b10;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wrap_q;
    logic              wrap_d;
    logic [DATA_W:0]   arith_w;

    // Next-state: only the selected register changes; the extra MSB of arith_w
    // carries the inc carry-out or the dec borrow.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        wrap_d  = wrap_q & ~clear_wrap;
        arith_w = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (read_or_write == SEL_W'(i + 1)) begin
                case (write_mode)
                    MODE_LOAD: regs_d[i] = write_data;
                    MODE_INC: begin
                        arith_w   = {1'b0, regs_q[i]} + {1'b0, STEP_V};
                        regs_d[i] = arith_w[DATA_W-1:0];
                        if (arith_w[DATA_W]) wrap_d = 1'b1;
                    end
                    MODE_DEC: begin
                        arith_w   = {1'b0, regs_q[i]} - {1'b0, STEP_V};
                        regs_d[i] = arith_w[DATA_W-1:0];
                        if (arith_w[DATA_W]) wrap_d = 1'b1;
                    end
                    default: begin
                        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                            if (byte_en[b]) regs_d[i][b*8 +: 8] = write_data[b*8 +: 8];
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock_6 or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_V;
            end
            wrap_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wrap_q <= wrap_d;
        end
    end

    // Read ports come straight from stored state; unmatched selects read zero.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_sel_a == SEL_W'(i + 1)) rd_data_a = regs_q[i];
            if (rd_sel_b == SEL_W'(i + 1)) rd_data_b = regs_q[i];
        end
    end

    assign wrap_flag = wrap_q;

endmodule

// File: tb/tb_gp_register_bank.sv
// Directed bench for gp_register_bank: a reference model pushes expectations to
// a scoreboard queue, which is popped and compared against the DUT outputs.
module tb_gp_register_bank;

    logic        clock_6 = 1'b0;
    logic        reset;
    logic [3:0]  read_or_write;
    logic [1:0]  write_mode;
    logic [3:0]  byte_en;
    logic [31:0] write_data;
    logic [3:0]  rd_sel_a;
    logic [3:0]  rd_sel_b;
    logic        clear_wrap;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        wrap_flag;

    gp_register_bank dut (
        .clock_6       (clock_6),
        .reset         (reset),
        .read_or_write (read_or_write),
        .write_mode    (write_mode),
        .byte_en       (byte_en),
        .write_data    (write_data),
        .rd_sel_a      (rd_sel_a),
        .rd_sel_b      (rd_sel_b),
        .clear_wrap    (clear_wrap),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .wrap_flag     (wrap_flag)
    );

    always #5 clock_6 = ~clock_6;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        scb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m     [8];
    logic [31:0] m_nxt [8];
    logic        mw;
    logic        mw_nxt;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        scb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (scb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with no expectation", obs);
        end else begin
            e = scb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [31:0] mread(input logic [3:0] s);
        int k;
        k = int'(s);
        if (k >= 1 && k <= 8) return m[k-1];
        return 32'h0;
    endfunction

    task automatic rd(input string tag, input logic [3:0] sa, input logic [3:0] sb);
        rd_sel_a = sa;
        rd_sel_b = sb;
        #1;
        push({tag, "_a"}, mread(sa));
        push({tag, "_b"}, mread(sb));
        pop_cmp(rd_data_a);
        pop_cmp(rd_data_b);
    endtask

    task automatic chk_const(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_cmp(obs);
    endtask

    task automatic chk_wrap(input string tag);
        push(tag, {31'b0, mw});
        pop_cmp({31'b0, wrap_flag});
    endtask

    // Drive one write at the falling edge and compute the model's post-edge state.
    task automatic drive(input logic [3:0] sel, input logic [1:0] mode, input logic [3:0] be,
                         input logic [31:0] data, input logic clr);
        int          k;
        logic [32:0] t;
        @(negedge clock_6);
        read_or_write = sel;
        write_mode    = mode;
        byte_en       = be;
        write_data    = data;
        clear_wrap    = clr;
        m_nxt  = m;
        mw_nxt = mw & ~clr;
        k = int'(sel);
        if (k >= 1 && k <= 8) begin
            case (mode)
                2'b00: m_nxt[k-1] = data;
                2'b01: begin
                    t = {1'b0, m[k-1]} + 33'd4;
                    m_nxt[k-1] = t[31:0];
                    if (t[32]) mw_nxt = 1'b1;
                end
                2'b10: begin
                    if (m[k-1] < 32'd4) mw_nxt = 1'b1;
                    m_nxt[k-1] = m[k-1] - 32'd4;
                end
                default: begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m_nxt[k-1][b*8 +: 8] = data[b*8 +: 8];
                end
            endcase
        end
    endtask

    task automatic commit();
        @(posedge clock_6);
        m  = m_nxt;
        mw = mw_nxt;
        #1;
        read_or_write = 4'd0;
        write_mode    = 2'b00;
        byte_en       = 4'd0;
        write_data    = 32'h0;
        clear_wrap    = 1'b0;
    endtask

    task automatic wr(input logic [3:0] sel, input logic [1:0] mode, input logic [3:0] be,
                      input logic [31:0] data, input logic clr);
        drive(sel, mode, be, data, clr);
        commit();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 32'h0000_0888;
        mw = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        read_or_write = 4'd5;
        write_mode    = 2'b00;
        byte_en       = 4'hF;
        write_data    = 32'hCAFE_F00D;
        rd_sel_a      = 4'd0;
        rd_sel_b      = 4'd0;
        clear_wrap    = 1'b1;
        model_reset();

        // Writes driven while reset is held must be ignored.
        repeat (2) @(posedge clock_6);
        #1;
        rd("in_reset", 4'd5, 4'd9);
        chk_const("in_reset_const", rd_data_a, 32'h0000_0888);
        chk_wrap("in_reset_wrap");

        @(negedge clock_6);
        read_or_write = 4'd0;
        clear_wrap    = 1'b0;
        reset         = 1'b0;

        for (int s = 0; s < 16; s++) rd("sel_sweep", 4'(s), 4'(15 - s));
        chk_wrap("wrap_after_reset");

        // No write bypass: same-cycle read sees the old value.
        drive(4'd6, 2'b00, 4'h0, 32'hDEAD_BEEF, 1'b0);
        rd("same_cycle", 4'd6, 4'd1);
        chk_const("same_cycle_const", rd_data_a, 32'h0000_0888);
        commit();
        rd("load6", 4'd6, 4'd6);
        chk_const("load6_const", rd_data_b, 32'hDEAD_BEEF);
        for (int s = 1; s <= 8; s++) rd("others", 4'(s), 4'(s));

        wr(4'd2, 2'b00, 4'h0, 32'hFFFF_FFFE, 1'b0);
        chk_wrap("load_no_wrap");
        wr(4'd2, 2'b01, 4'h0, 32'h1234_5678, 1'b0);
        rd("inc_wrap", 4'd2, 4'd6);
        chk_const("inc_wrap_const", rd_data_a, 32'h0000_0002);
        chk_wrap("inc_wrap_flag");
        wr(4'd0, 2'b00, 4'h0, 32'h0, 1'b0);
        chk_wrap("wrap_sticky");
        wr(4'd0, 2'b00, 4'h0, 32'h0, 1'b1);
        chk_wrap("wrap_cleared");

        wr(4'd3, 2'b00, 4'h0, 32'h0000_0002, 1'b0);
        wr(4'd3, 2'b10, 4'h0, 32'h0, 1'b1);
        rd("dec_wrap", 4'd3, 4'd3);
        chk_const("dec_wrap_const", rd_data_b, 32'hFFFF_FFFE);
        chk_wrap("set_wins");

        // Invalid selects touch nothing, including the flag.
        wr(4'd9, 2'b01, 4'h0, 32'h0, 1'b0);
        wr(4'd0, 2'b00, 4'h0, 32'h5555_5555, 1'b0);
        for (int s = 1; s <= 8; s++) rd("invalid_sel", 4'(s), 4'(s + 8));
        chk_wrap("invalid_keeps_wrap");
        wr(4'd15, 2'b00, 4'h0, 32'h0, 1'b1);
        chk_wrap("clear_on_invalid");

        wr(4'd1, 2'b11, 4'b1010, 32'h1122_3344, 1'b0);
        rd("merge", 4'd1, 4'd1);
        chk_const("merge_const", rd_data_a, 32'h1100_3388);
        wr(4'd1, 2'b11, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        rd("merge_none", 4'd1, 4'd2);
        wr(4'd5, 2'b10, 4'h0, 32'h0, 1'b0);
        rd("dec_plain", 4'd5, 4'd4);
        chk_const("dec_plain_const", rd_data_a, 32'h0000_0884);
        chk_wrap("dec_no_wrap");
        wr(4'd8, 2'b01, 4'h0, 32'h0, 1'b0);
        rd("inc_plain", 4'd8, 4'd8);

        // Set the flag, then pulse reset across an edge with a write pending.
        wr(4'd7, 2'b00, 4'h0, 32'hFFFF_FFFC, 1'b0);
        wr(4'd7, 2'b01, 4'h0, 32'h0, 1'b0);
        chk_wrap("pre_reset_wrap");
        @(negedge clock_6);
        read_or_write = 4'd4;
        write_mode    = 2'b00;
        write_data    = 32'h0BAD_0BAD;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        rd("async_rst", 4'd4, 4'd7);
        chk_const("async_rst_const", rd_data_a, 32'h0000_0888);
        chk_wrap("async_rst_wrap");
        @(posedge clock_6);
        #2;
        reset = 1'b0;
        rd("write_discarded", 4'd4, 4'd6);
        wr(4'd4, 2'b00, 4'h0, 32'h0000_1234, 1'b0);
        rd("post_reset_write", 4'd4, 4'd3);
        chk_const("post_reset_const", rd_data_a, 32'h0000_1234);

        if (scb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", scb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
